// File: rtl/window_buf_loader_if.sv
// Controller/memory-facing bundle of window_buf_loader. Under WBL_CMD_ERR_EN it also
// carries the sticky cmdErr flag.
interface window_buf_loader_if #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int ADDR_W = 8
);
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic                   initLd;
    logic                   ldBuf;
    logic [DATA_W-1:0]      memRdData;
    logic                   memRdEn;
    logic [ADDR_W-1:0]      memAddr;
    logic                   ldBufDone;
    logic                   ctrlDone;
    logic [K*K*DATA_W-1:0]  window;
    logic [ROW_W-1:0]       winRow;
    logic [COL_W-1:0]       winCol;
`ifdef WBL_CMD_ERR_EN
    logic                   cmdErr;

    modport master (output initLd, ldBuf, memRdData,
                    input  memRdEn, memAddr, ldBufDone, ctrlDone, window, winRow, winCol, cmdErr);
    modport slave  (input  initLd, ldBuf, memRdData,
                    output memRdEn, memAddr, ldBufDone, ctrlDone, window, winRow, winCol, cmdErr);
`else
    modport master (output initLd, ldBuf, memRdData,
                    input  memRdEn, memAddr, ldBufDone, ctrlDone, window, winRow, winCol);
    modport slave  (input  initLd, ldBuf, memRdData,
                    output memRdEn, memAddr, ldBufDone, ctrlDone, window, winRow, winCol);
`endif
endinterface

// File: rtl/window_buf_loader.sv
// Sliding K x K window loader (stride 1, raster order) over a 1-cycle-latency memory.
// Optional feature macro: WBL_CMD_ERR_EN adds the sticky cmdErr output.
module window_buf_loader #(
    parameter int DATA_W    = 8,
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8,
    parameter int K         = 3,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    window_buf_loader_if.slave bus
);
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - K);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - K);
    localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(K - 1);
    localparam logic             CTRL_RST = (IMG_H == K) && (IMG_W == K);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    state_e                state_q, state_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [IDX_W-1:0]      rd_r_q, rd_r_d, rd_c_q, rd_c_d;
    logic                  pend_q, pend_d;
    logic [IDX_W-1:0]      pend_r_q, pend_r_d, pend_c_q, pend_c_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic                  ld_done_q, ld_done_d;
    logic                  ctrl_done_q, ctrl_done_d;
    logic [K*K*DATA_W-1:0] window_q, window_d;
    logic                  cmd_err_q, cmd_err_d;
    logic                  start, at_last, ignored;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col,
                                                   input logic [IDX_W-1:0] r,
                                                   input logic [IDX_W-1:0] c);
        return ADDR_W'(BASE_ADDR) + (ADDR_W'(row) + ADDR_W'(r)) * ADDR_W'(IMG_W)
               + ADDR_W'(col) + ADDR_W'(c);
    endfunction

    // NOTE: every signal gets a default at the top of always_comb, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        rd_r_d      = rd_r_q;
        rd_c_d      = rd_c_q;
        pend_d      = mem_rd_en_q;
        pend_r_d    = rd_r_q;
        pend_c_d    = rd_c_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        window_d    = window_q;
        cmd_err_d   = cmd_err_q;
        start       = 1'b0;
        ignored     = 1'b0;
        at_last     = (row_q == LAST_ROW) && (col_q == LAST_COL);

        // Read data returns one cycle after its strobe; pend_* remembers where it belongs.
        if (pend_q)
            window_d[(int'(pend_r_q) * K + int'(pend_c_q)) * DATA_W +: DATA_W] = bus.memRdData;

        unique case (state_q)
            IDLE: begin
                if (bus.initLd) begin
                    start     = 1'b1;
                    row_d     = '0;
                    col_d     = '0;
                    rd_r_d    = '0;
                    rd_c_d    = '0;
                    cmd_err_d = 1'b0;
                end else if (bus.ldBuf && !at_last) begin
                    start  = 1'b1;
                    rd_r_d = '0;
                    if (col_q == LAST_COL) begin
                        row_d  = row_q + 1'b1;
                        col_d  = '0;
                        rd_c_d = '0;
                    end else begin
                        col_d  = col_q + 1'b1;
                        rd_c_d = K_LAST;
                        for (int r = 0; r < K; r++)
                            for (int c = 0; c < K - 1; c++)
                                window_d[(r * K + c) * DATA_W +: DATA_W] =
                                    window_q[(r * K + c + 1) * DATA_W +: DATA_W];
                    end
                end else if (bus.ldBuf) begin
                    ignored = 1'b1;
                end
                if (start) begin
                    state_d     = ISSUE;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = pix_addr(row_d, col_d, rd_r_d, rd_c_d);
                end
            end
            ISSUE: begin
                ignored = bus.initLd || bus.ldBuf;
                // Both load shapes end on element (K-1, K-1).
                if (rd_r_q == K_LAST && rd_c_q == K_LAST) begin
                    state_d = DRAIN;
                end else begin
                    if (rd_r_q == K_LAST) begin
                        rd_r_d = '0;
                        rd_c_d = rd_c_q + 1'b1;
                    end else begin
                        rd_r_d = rd_r_q + 1'b1;
                    end
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = pix_addr(row_q, col_q, rd_r_d, rd_c_d);
                end
            end
            DRAIN: begin
                ignored = bus.initLd || bus.ldBuf;
                state_d = DONE;
            end
            default: begin
                ignored = bus.initLd || bus.ldBuf;
                state_d = IDLE;
            end
        endcase

        if (ignored)
            cmd_err_d = 1'b1;
        ld_done_d   = (state_d == DONE);
        ctrl_done_d = (state_d == IDLE) && (row_d == LAST_ROW) && (col_d == LAST_COL);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            rd_r_q      <= '0;
            rd_c_q      <= '0;
            pend_q      <= 1'b0;
            pend_r_q    <= '0;
            pend_c_q    <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            ld_done_q   <= 1'b0;
            ctrl_done_q <= CTRL_RST;
            // NOTE: the window storage is reset too; it is a visible output that must read all-zero after reset.
            window_q    <= '0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rd_r_q      <= rd_r_d;
            rd_c_q      <= rd_c_d;
            pend_q      <= pend_d;
            pend_r_q    <= pend_r_d;
            pend_c_q    <= pend_c_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            ld_done_q   <= ld_done_d;
            ctrl_done_q <= ctrl_done_d;
            window_q    <= window_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign bus.memRdEn   = mem_rd_en_q;
    assign bus.memAddr   = mem_addr_q;
    assign bus.ldBufDone = ld_done_q;
    assign bus.ctrlDone  = ctrl_done_q;
    assign bus.window    = window_q;
    assign bus.winRow    = row_q;
    assign bus.winCol    = col_q;
`ifdef WBL_CMD_ERR_EN
    assign bus.cmdErr    = cmd_err_q;
`endif
endmodule
